// File: rtl/imem_loader.sv
// Writable instruction memory with a big-endian byte-stream loader.
// The CPU is held in reset until the requested number of words has been written.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       read_addr,
    output logic [31:0]       instruction,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are
    // both 1; rx_valid low is a stall with no side effects.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     MEM_SPAN = 32'(4 * DEPTH);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] word_idx_q,  word_idx_d;
    logic [1:0]        byte_cnt_q,  byte_cnt_d;
    logic [23:0]       shift_q,     shift_d;
    logic [ADDR_W:0]   len_q,       len_d;
    logic              rx_ready_q,  rx_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q,  load_err_d;

    logic              len_legal;
    logic              last_word;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem [DEPTH];

    always_comb begin
        len_legal   = (load_len != '0) && (load_len <= DEPTH_L);
        last_word   = ({1'b0, word_idx_q} == (len_q - 1'b1));

        state_d     = state_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        len_d       = len_q;
        load_err_d  = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = {shift_q, rx_data};

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (len_legal) begin
                        state_d    = ST_LOAD;
                        len_d      = load_len;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // rx_ready is 1 throughout LOAD, so rx_valid alone means accept.
                if (rx_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = '0;
                        if (last_word) begin
                            state_d = ST_RUN;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are decoded from the next state and then registered.
        rx_ready_d  = (state_d == ST_LOAD);
        cpu_reset_d = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            len_q       <= '0;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            rx_ready_q  <= rx_ready_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // RAM keeps its contents across reset; a reset on the final byte's edge
    // discards that word.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[word_idx_q] <= mem_wdata;
        end
    end

    always_comb begin
        instruction = '0;
        if (read_addr < MEM_SPAN) begin
            instruction = mem[read_addr[ADDR_W+1:2]];
        end
    end

    assign rx_ready  = rx_ready_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drivers queue expected values, a negedge
// monitor pops and compares them, and tracks load_err pulses.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int SEL_INSN  = 0;
    localparam int SEL_FLAGS = 1;
    localparam int SEL_STATE = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [31:0]       read_addr;
    logic [31:0]       instruction;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [1:0]        dbg_state;

    int          vectors     = 0;
    int          miscompares = 0;
    int          err_expect  = 0;
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];

    int          mon_sel;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    string       mon_nm;

    logic [7:0]  prog [8] = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    logic [7:0]  prog1 [4] = '{8'h08, 8'h00, 8'h00, 8'h3F};

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_len    (load_len),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .read_addr   (read_addr),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_err    (load_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_sel = sel_q.pop_front();
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            case (mon_sel)
                SEL_INSN:  mon_act = instruction;
                SEL_FLAGS: mon_act = {28'd0, rx_ready, cpu_reset, load_done, load_err};
                default:   mon_act = {30'd0, dbg_state};
            endcase
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", mon_nm, mon_act, mon_exp);
            end
        end
        if (load_err) begin
            vectors++;
            if (err_expect == 0) begin
                miscompares++;
                $display("FAIL load_err_unexpected: got 1, expected 0");
            end else begin
                err_expect--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_val(input int sel, input logic [31:0] exp, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // flags order: rx_ready, cpu_reset, load_done, load_err
    task automatic expect_flags(input logic [3:0] f, input string nm);
        expect_val(SEL_FLAGS, {28'd0, f}, nm);
        settle();
    endtask

    task automatic expect_state(input logic [1:0] s, input string nm);
        expect_val(SEL_STATE, {30'd0, s}, nm);
        settle();
    endtask

    task automatic check_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        read_addr = addr;
        expect_val(SEL_INSN, exp, nm);
        settle();
    endtask

    // rx_ready is registered, so its value between edges is what the next edge sees.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 16 && !acc; i++) begin
            acc = rx_ready;
            tick();
        end
        rx_valid = 1'b0;
        rx_data  = 8'hEE;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: rx_ready got 0, expected 1");
        end
    endtask

    task automatic start_load(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
        load_len   = '0;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {16'hC0DE, b, b ^ 8'h5A};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        read_addr  = 32'h0;
        tick();
        tick();
        expect_flags(4'b0100, "reset_flags");
        expect_state(2'd0, "reset_state");
        reset = 1'b0;
        tick();

        // Two-word load on consecutive cycles.
        start_load(7'd2);
        expect_flags(4'b1100, "t1_load_entered");
        for (int k = 0; k < 8; k++) send_byte(prog[k]);
        expect_flags(4'b0010, "t1_run_after_8th");
        expect_state(2'd2, "t1_state_run");
        check_read(32'h0, 32'h20080020, "t1_mem0");
        check_read(32'h4, 32'h20090037, "t1_mem1_a4");
        check_read(32'h7, 32'h20090037, "t1_mem1_a7");

        // Same load re-entered from RUN with rx_valid 1,0,0 pattern.
        start_load(7'd2);
        expect_flags(4'b1100, "t2_reenter");
        for (int k = 0; k < 8; k++) begin
            send_byte(prog[k]);
            if (k == 6) expect_flags(4'b1100, "t2_held_after_7th");
            if (k < 7) begin
                rx_data = 8'hFF;
                tick();
                tick();
            end
        end
        expect_flags(4'b0010, "t2_run_after_8th");
        check_read(32'h0, 32'h20080020, "t2_mem0");
        check_read(32'h4, 32'h20090037, "t2_mem1");

        // Illegal lengths in RUN and in IDLE.
        err_expect++;
        start_load(7'd0);
        expect_flags(4'b0011, "t3_err_in_run");
        expect_flags(4'b0010, "t3_err_cleared_run");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        err_expect++;
        start_load(7'd0);
        expect_flags(4'b0101, "t3_err_len0");
        expect_flags(4'b0100, "t3_err_len0_cleared");
        err_expect++;
        start_load(7'd65);
        expect_flags(4'b0101, "t3_err_len65");
        expect_flags(4'b0100, "t3_err_len65_cleared");
        expect_state(2'd0, "t3_state_idle");

        // Reset after 6 bytes of a 2-word load.
        start_load(7'd2);
        for (int k = 0; k < 6; k++) send_byte(prog[k]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_flags(4'b0100, "t4_after_reset");
        expect_state(2'd0, "t4_state_idle");
        check_read(32'h0, 32'h20080020, "t4_mem0");
        check_read(32'h4, 32'h20090037, "t4_mem1_kept");

        // load_start together with reset: reset wins.
        load_start = 1'b1;
        load_len   = 7'd2;
        reset      = 1'b1;
        tick();
        load_start = 1'b0;
        reset      = 1'b0;
        expect_flags(4'b0100, "t4_reset_wins");

        // Reload one word from RUN; load_start during LOAD is ignored.
        start_load(7'd2);
        for (int k = 0; k < 8; k++) send_byte(prog[k]);
        start_load(7'd1);
        expect_flags(4'b1100, "t5_cpu_reset_reassert");
        send_byte(prog1[0]);
        send_byte(prog1[1]);
        start_load(7'd0);
        expect_flags(4'b1100, "t5_start_ignored");
        send_byte(prog1[2]);
        expect_flags(4'b1100, "t5_held_after_3rd");
        send_byte(prog1[3]);
        expect_flags(4'b0010, "t5_run_after_4th");
        check_read(32'h0, 32'h0800003F, "t5_mem0");
        check_read(32'h4, 32'h20090037, "t5_mem1_unchanged");

        // Out-of-range read and a full-depth load.
        check_read(32'h100, 32'h0, "t6_oob_0x100");
        start_load(7'd64);
        for (int i = 0; i < DEPTH; i++) begin
            w = pat(i);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        expect_flags(4'b0010, "t6_full_run");
        check_read(32'hFC, 32'hC0DE3F65, "t6_mem63");
        check_read(32'h0, 32'hC0DE005A, "t6_mem0");
        check_read(32'h84, 32'hC0DE217B, "t6_mem33");
        check_read(32'h100, 32'h0, "t6_oob_after_load");
        check_read(32'hFFFFFFFC, 32'h0, "t6_oob_top");

        tick();
        vectors++;
        if (err_expect != 0) begin
            miscompares++;
            $display("FAIL load_err_missing: got %0d pulses short, expected 0", err_expect);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_checks: got %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
